// File: rtl/ebpf_adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit adder among NUM_REQ requesters; 1-cycle latency into a single output register.
// Backpressure: when the register is full and rsp_ready is low, every req_ready is 0 and all outputs hold.
module ebpf_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*64-1:0]   req_a,
    input  logic [NUM_REQ*64-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_alu32,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [63:0]             rsp_data,
    output logic                    rsp_carry,
    output logic [31:0]             op_count
);

    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] grant;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic [ID_W:0]   cand;
    logic [63:0]     sel_a;
    logic [63:0]     sel_b;
    logic            sel_alu32;
    logic [32:0]     sum32;
    logic [64:0]     sum;

    assign can_accept = !rsp_valid || rsp_ready;
    assign accept     = found && can_accept && !rst;

    // First valid index in the rotated order rr, rr+1, ..., rr-1.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                grant = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_alu32 = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a     = req_a[i*64 +: 64];
                sel_b     = req_b[i*64 +: 64];
                sel_alu32 = req_alu32[i];
            end
        end
    end

    // ALU32 mode zero-extends the low-word sum; its carry is bit 32.
    always_comb begin
        sum32 = {1'b0, sel_a[31:0]} + {1'b0, sel_b[31:0]};
        if (sel_alu32)
            sum = {sum32[32], 32'b0, sum32[31:0]};
        else
            sum = {1'b0, sel_a} + {1'b0, sel_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr        <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_id    <= grant;
                rsp_data  <= sum[63:0];
                rsp_carry <= sum[64];
                op_count  <= op_count + 32'd1;
                rr        <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ebpf_adder_arbiter.sv
// Bench for ebpf_adder_arbiter: directed cases then random traffic against a behavioural model.
module tb_ebpf_adder_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*64-1:0] req_a;
    logic [N*64-1:0] req_b;
    logic [N-1:0]    req_alu32;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [63:0]     rsp_data;
    logic            rsp_carry;
    logic [31:0]     op_count;

    ebpf_adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_alu32(req_alu32),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side pending operations.
    logic        pv   [N];
    logic [63:0] pa   [N];
    logic [63:0] pb   [N];
    logic        palu [N];

    // Model of the output register and arbitration fairness state.
    int          m_rr;
    logic        m_valid;
    logic [1:0]  m_id;
    logic [63:0] m_data;
    logic        m_carry;
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b, input logic alu32);
        logic [32:0] s;
        if (alu32) begin
            s = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            return {s[32], 32'b0, s[31:0]};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (pv[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_valid = 0; m_id = 0; m_data = 0; m_carry = 0; m_count = 0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pv[i];
            req_a[i*64 +: 64]   = pa[i];
            req_b[i*64 +: 64]   = pb[i];
            req_alu32[i]        = palu[i];
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic alu32);
        pv[i] = 1'b1; pa[i] = a; pb[i] = b; palu[i] = alu32;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; palu[i] = 1'b0;
        end
    endtask

    // One clock: called just after a falling edge with pv/rsp_ready prepared.
    task automatic step(input string tag);
        int          g;
        logic [N-1:0] er;
        logic        can, acc;
        logic [64:0] s;
        apply();
        #1;
        g   = winner();
        can = !m_valid || rsp_ready;
        acc = (g >= 0) && can;
        er  = '0;
        if (acc) er[g] = 1'b1;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(er));
        @(posedge clk);
        if (acc) begin
            s       = ref_sum(pa[g], pb[g], palu[g]);
            m_valid = 1'b1;
            m_id    = 2'(g);
            m_data  = s[63:0];
            m_carry = s[64];
            m_count = m_count + 32'd1;
            m_rr    = (g + 1) % N;
            pv[g]   = 1'b0;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
        chk({tag, ".rsp_id"},    64'(rsp_id),    64'(m_id));
        chk({tag, ".rsp_data"},  rsp_data,       m_data);
        chk({tag, ".rsp_carry"}, 64'(rsp_carry), 64'(m_carry));
        chk({tag, ".op_count"},  64'(op_count),  64'(m_count));
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, ".rsp_id"},    64'(rsp_id),    64'(0));
        chk({tag, ".rsp_data"},  rsp_data,       64'(0));
        chk({tag, ".rsp_carry"}, 64'(rsp_carry), 64'(0));
        chk({tag, ".op_count"},  64'(op_count),  64'(0));
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_reset_state(tag);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 64'(i), 64'(i), 1'b0);
        apply();
        model_reset();
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single op, 64-bit mode with full carry out.
        clear_reqs();
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        step("single64");
        chk("single64.id_is_2", 64'(rsp_id), 64'd2);

        // ALU32 mode ignores the upper operand bits.
        set_req(3, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0002, 1'b1);
        step("alu32");
        chk("alu32.data", rsp_data, 64'h0000_0000_0000_0001);
        chk("alu32.carry", 64'(rsp_carry), 64'd1);

        // Round-robin with all requesters valid from reset.
        pulse_reset("rr_reset");
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'(k & 1));
            step("rr");
            chk("rr.order", 64'(rsp_id), 64'(k % N));
        end

        // Back-pressure: register full, consumer stalled, requesters 1 and 3 waiting.
        clear_reqs();
        set_req(1, 64'h1111, 64'h2222, 1'b0);
        set_req(3, 64'h3333, 64'h4444, 1'b0);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) step("stall");
        rsp_ready = 1'b1;
        step("stall_release");
        chk("stall_release.valid_held", 64'(rsp_valid), 64'd1);

        // Random traffic with back-pressure.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 7) == 0) pa[i] = '1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // Reset while a result is held and rr points at requester 3.
        rsp_ready = 1'b1;
        pulse_reset("pre_mid");
        clear_reqs();
        set_req(2, 64'd5, 64'd7, 1'b0);
        step("mid_setup");
        chk("mid_setup.data", rsp_data, 64'd12);
        pulse_reset("mid_reset");
        set_req(0, 64'd1, 64'd2, 1'b0);
        set_req(3, 64'd3, 64'd4, 1'b0);
        step("after_reset");
        chk("after_reset.winner", 64'(rsp_id), 64'd0);

        // Counter wrap.
        clear_reqs();
        force dut.op_count = 32'hFFFF_FFFF;
        #1;
        release dut.op_count;
        m_count = 32'hFFFF_FFFF;
        set_req(1, 64'd9, 64'd9, 1'b0);
        step("wrap");
        chk("wrap.zero", 64'(op_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
